csd_twiddle_seq: RTL and testbench
==================================

// Module: csd_twiddle_seq
// PURPOSE
//  Sequencer for one FFT-stage CSD twiddle multiplier. Accepts a valid/ready sample stream framed by in_sof.
//  Tracks the in-frame sample index and drives the multiplier's csd select: 1 = trivial twiddle (scaled
//  pass-through), 0 = CSD constant. Registers the multiplier product and emits an output stream with sof/eof.
//  Sits between the stage butterfly and the next stage's reorder buffer.
// PARAMETERS
//  NBITS       12                      sample component width (real and imag each)
//  NBITScoeff  11                      twiddle coefficient width; sets pass-through scaling
//  NBITS_out   NBITS+NBITScoeff+1      product component width
//  NFFT        128                     frame length in samples; power of two, >= BLOCK
//  BLOCK       8                       csd period in samples; power of two, >= 2
// PORTS
//  clk          in   1            clock; all logic rising-edge
//  rst          in   1            synchronous, active-high reset
//  in_data      in   2*NBITS      {real, imag} sample
//  in_valid     in   1            in_data valid
//  in_sof       in   1            qualifies in_data as frame sample 0
//  in_ready     out  1            block accepts in_data this cycle
//  mult_sample  out  2*NBITS      to multiplier muestra; equals in_data
//  mult_csd     out  1            to multiplier csd select
//  mult_result  in   2*NBITS_out  combinational product returned by the multiplier
//  out_data     out  2*NBITS_out  registered product {real, imag}
//  out_valid    out  1            out_data valid
//  out_sof      out  1            out_data is frame index 0
//  out_eof      out  1            out_data is frame index NFFT-1
//  out_ready    in   1            downstream accepts out_data
//  frame_err    out  1            one-cycle pulse on an out-of-place sof
//  frames_done  out  16           count of completed frames; saturates at 16'hFFFF
// BEHAVIOUR
//  - Accept = in_valid & in_ready. in_ready = ~out_valid | out_ready (combinational, single output register).
//  - FSM: IDLE, RUN. Reset -> IDLE, idx=0.
//    IDLE: accepted samples without sof are dropped (in_ready=1, nothing forwarded).
//          Accepted sof -> forward it as idx 0 and go to RUN with idx=1.
//    RUN: each accepted sample is forwarded and idx increments.
//         Accepting idx NFFT-1 -> out_eof on that sample, frames_done++, go to IDLE, idx=0.
//  - Sof accepted in RUN with idx!=0: frame_err pulses the next cycle. The sample is forwarded as idx 0
//    (out_sof=1). idx restarts; the aborted frame gets no eof and does not increment frames_done.
//  - mult_csd = (idx mod BLOCK) < BLOCK/2, where idx is the index of the sample currently presented.
//    A sof presents index 0, so mult_csd=1. Combinational from the idx register and in_sof.
//  - Latency: accepted sample at cycle t -> out_data/out_valid at t+1. out_sof/out_eof are registered with it.
//  - Output register loads mult_result whenever a sample is forwarded.
//    out_valid clears on out_ready when no new sample is forwarded.
//    With out_valid=1 and out_ready=0, out_data/out_sof/out_eof hold stable; idx does not advance.
//  - Width rule: out_data is mult_result unmodified; no rounding or saturation in this block.
//  - Reset values: out_valid=0, out_data=0, out_sof=0, out_eof=0, frame_err=0, frames_done=0.
//    Reset mid-frame abandons the frame and drops any held output.
// STRUCTURE
//  - Shared package fft_ctrl_pkg: FSM state encoding (IDLE, RUN), NFFT/BLOCK defaults, idx width clog2(NFFT).
//  - One sub-module, csd_phase_cnt: idx counter with load-zero/enable, terminal-count flag, and csd decode.
//  - Output register and FSM stay in this module. The multiplier is instantiated by the parent.
// TESTING (NFFT=128, BLOCK=8, NBITS=12, NBITScoeff=11, bench models the CSD multiplier)
//  1. Hold rst for 2 cycles -> out_valid=0, frame_err=0, frames_done=0, in_ready=1, mult_csd=1.
//  2. Full frame, in_data real=1/imag=0 each cycle, out_ready=1:
//     -> mult_csd pattern 1111_0000 repeated; idx0 out real=512, imag=0; idx4 out real=-363, imag=-363.
//     -> out_sof on first output, out_eof on output 128, frames_done=1.
//  3. out_ready=0 for 3 cycles at idx 20 -> in_ready=0, out_data held, mult_csd frozen.
//     -> After release, idx 21 appears next with no sample lost or duplicated.
//  4. sof at idx 50 -> frame_err high one cycle; that sample out with out_sof=1; next mult_csd=1 (idx 1).
//     -> frames_done unchanged.
//  5. 10 valid samples without sof while in IDLE -> no out_valid, in_ready=1 throughout.
//  6. rst asserted at idx 70 with out_valid=1 -> next cycle out_valid=0.
//     -> Samples without sof are then dropped until a new sof.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared control definitions for FFT stage sequencers: FSM encoding and frame defaults.
package fft_ctrl_pkg;

   localparam int unsigned NFFT_DEF  = 128;
   localparam int unsigned BLOCK_DEF = 8;
   localparam int unsigned IDX_W_DEF = $clog2(NFFT_DEF);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/csd_phase_cnt.sv
// In-frame sample index counter with terminal-count flag and CSD select decode.
module csd_phase_cnt
   import fft_ctrl_pkg::*;
#(
   parameter int unsigned NFFT  = NFFT_DEF,
   parameter int unsigned BLOCK = BLOCK_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_clr,
   input  logic                    i_en,
   input  logic                    i_sof,
   output logic [$clog2(NFFT)-1:0] o_idx,
   output logic                    o_tc_c,
   output logic                    o_csd_c
);

   localparam int unsigned IDX_W = $clog2(NFFT);
   localparam int unsigned BLK_W = $clog2(BLOCK);

   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_nxt;

   // clr and en together restart the count at 1 (the sof sample itself is index 0)
   always_comb begin
      w_idx_nxt = (i_clr ? '0 : r_idx) + IDX_W'(i_en);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx <= '0;
      end else begin
         r_idx <= w_idx_nxt;
      end
   end

   assign o_idx   = r_idx;
   assign o_tc_c  = (r_idx == IDX_W'(NFFT - 1));
   // lower half of each BLOCK period uses the trivial twiddle; a sof presents index 0
   assign o_csd_c = i_sof | ~r_idx[BLK_W-1];

endmodule

// File: rtl/csd_twiddle_seq.sv
// Sequencer for one FFT-stage CSD twiddle multiplier: frames the sample stream,
// drives the csd select and registers the product with sof/eof framing.
module csd_twiddle_seq
   import fft_ctrl_pkg::*;
#(
   parameter int unsigned NBITS      = 12,
   parameter int unsigned NBITScoeff = 11,
   parameter int unsigned NFFT       = NFFT_DEF,
   parameter int unsigned BLOCK      = BLOCK_DEF
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [2*NBITS-1:0]                  in_data,
   input  logic                                in_valid,
   input  logic                                in_sof,
   output logic                                in_ready,
   output logic [2*NBITS-1:0]                  mult_sample,
   output logic                                mult_csd,
   input  logic [2*(NBITS+NBITScoeff+1)-1:0]   mult_result,
   output logic [2*(NBITS+NBITScoeff+1)-1:0]   out_data,
   output logic                                out_valid,
   output logic                                out_sof,
   output logic                                out_eof,
   input  logic                                out_ready,
   output logic                                frame_err,
   output logic [15:0]                         frames_done
);

   localparam int unsigned NBITS_out = NBITS + NBITScoeff + 1;
   localparam int unsigned IDX_W     = $clog2(NFFT);

   logic [0:0]             r_state;
   logic [0:0]             w_state_nxt;
   logic [2*NBITS_out-1:0] r_out_data;
   logic                   r_out_valid;
   logic                   r_out_sof;
   logic                   r_out_eof;
   logic                   r_frame_err;
   logic [15:0]            r_frames_done;

   logic                   w_accept;
   logic                   w_fwd;
   logic                   w_clr;
   logic                   w_en;
   logic                   w_sof_out;
   logic                   w_eof_out;
   logic                   w_err;
   logic                   w_done;
   logic [IDX_W-1:0]       w_idx;
   logic                   w_tc;
   logic                   w_csd;

   csd_phase_cnt #(
      .NFFT  (NFFT),
      .BLOCK (BLOCK)
   ) u_phase (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_clr),
      .i_en    (w_en),
      .i_sof   (in_sof),
      .o_idx   (w_idx),
      .o_tc_c  (w_tc),
      .o_csd_c (w_csd)
   );

   // single output register: a new sample fits whenever the held one leaves
   assign in_ready    = ~r_out_valid | out_ready;
   assign w_accept    = in_valid & in_ready;
   assign mult_sample = in_data;
   assign mult_csd    = w_csd;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next state and per-sample control
   always_comb begin
      w_state_nxt = r_state;
      w_fwd       = 1'b0;
      w_clr       = 1'b0;
      w_en        = 1'b0;
      w_sof_out   = 1'b0;
      w_eof_out   = 1'b0;
      w_err       = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && in_sof) begin
               w_fwd       = 1'b1;
               w_clr       = 1'b1;
               w_en        = 1'b1;
               w_sof_out   = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_accept) begin
               w_fwd = 1'b1;
               if (in_sof) begin
                  // out-of-place sof aborts the frame and starts a new one
                  w_clr     = 1'b1;
                  w_en      = 1'b1;
                  w_sof_out = 1'b1;
                  w_err     = (w_idx != '0);
               end else if (w_tc) begin
                  w_eof_out   = 1'b1;
                  w_done      = 1'b1;
                  w_clr       = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_en = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_data    <= '0;
         r_out_valid   <= 1'b0;
         r_out_sof     <= 1'b0;
         r_out_eof     <= 1'b0;
         r_frame_err   <= 1'b0;
         r_frames_done <= '0;
      end else begin
         r_frame_err <= w_err;
         if (w_done && (r_frames_done != 16'hFFFF)) begin
            r_frames_done <= r_frames_done + 16'd1;
         end
         if (w_fwd) begin
            r_out_data  <= mult_result;
            r_out_valid <= 1'b1;
            r_out_sof   <= w_sof_out;
            r_out_eof   <= w_eof_out;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
         end
      end
   end

   assign out_data    = r_out_data;
   assign out_valid   = r_out_valid;
   assign out_sof     = r_out_sof;
   assign out_eof     = r_out_eof;
   assign frame_err   = r_frame_err;
   assign frames_done = r_frames_done;

endmodule

// File: tb/tb_csd_twiddle_seq.sv
// Directed bench for csd_twiddle_seq with a behavioural CSD multiplier model.
module tb_csd_twiddle_seq;

   localparam int unsigned NFFT  = 128;
   localparam int unsigned BLOCK = 8;
   localparam logic [23:0] M363  = 24'hFFFE95;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] in_data;
   logic        in_valid;
   logic        in_sof;
   logic        in_ready;
   logic [23:0] mult_sample;
   logic        mult_csd;
   logic [47:0] mult_result;
   logic [47:0] out_data;
   logic        out_valid;
   logic        out_sof;
   logic        out_eof;
   logic        out_ready;
   logic        frame_err;
   logic [15:0] frames_done;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   csd_twiddle_seq #(
      .NBITS      (12),
      .NBITScoeff (11),
      .NFFT       (NFFT),
      .BLOCK      (BLOCK)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_sof      (in_sof),
      .in_ready    (in_ready),
      .mult_sample (mult_sample),
      .mult_csd    (mult_csd),
      .mult_result (mult_result),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_sof     (out_sof),
      .out_eof     (out_eof),
      .out_ready   (out_ready),
      .frame_err   (frame_err),
      .frames_done (frames_done)
   );

   // csd=1: pass-through scaled by 2^9; csd=0: multiply by (-363 - j363)
   function automatic logic [47:0] mult_model(input logic [23:0] s, input logic csd);
      int re;
      int im;
      re = int'(signed'(s[23:12]));
      im = int'(signed'(s[11:0]));
      if (csd) return {24'(re * 512), 24'(im * 512)};
      return {24'(im * 363 - re * 363), 24'(-(re * 363) - im * 363)};
   endfunction

   assign mult_result = mult_model(mult_sample, mult_csd);

   function automatic logic csd_of(input int idx);
      return (idx % BLOCK) < (BLOCK / 2);
   endfunction

   task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // present one sample, check the combinational controls, then the registered output
   task automatic send(input logic sof, input int re, input int im, input int eidx, input logic eeof);
      in_valid = 1'b1;
      in_sof   = sof;
      in_data  = {12'(re), 12'(im)};
      #1;
      chk("in_ready", 48'(in_ready), 48'd1);
      chk("mult_csd", 48'(mult_csd), 48'(csd_of(eidx)));
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      chk("out_valid", 48'(out_valid), 48'd1);
      chk("out_data", out_data, mult_model({12'(re), 12'(im)}, csd_of(eidx)));
      chk("out_sof", 48'(out_sof), 48'(eidx == 0));
      chk("out_eof", 48'(out_eof), 48'(eeof));
   endtask

   task automatic drop_samples(input int n);
      for (int k = 0; k < n; k++) begin
         in_valid = 1'b1;
         in_sof   = 1'b0;
         in_data  = {12'(k + 3), 12'd0};
         #1;
         chk("idle_ready", 48'(in_ready), 48'd1);
         chk("idle_csd", 48'(mult_csd), 48'd1);
         @(posedge clk); #1;
         chk("idle_no_valid", 48'(out_valid), 48'd0);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 48'(out_valid), 48'd0);
      chk("rst_frame_err", 48'(frame_err), 48'd0);
      chk("rst_frames_done", 48'(frames_done), 48'd0);
      chk("rst_in_ready", 48'(in_ready), 48'd1);
      chk("rst_mult_csd", 48'(mult_csd), 48'd1);
      chk("rst_out_data", out_data, 48'd0);
      rst = 1'b0;

      // full frame of real=1, imag=0
      for (int i = 0; i < NFFT; i++) begin
         send(i == 0, 1, 0, i, i == NFFT - 1);
         if (i == 0) chk("idx0_value", out_data, {24'd512, 24'd0});
         if (i == 4) chk("idx4_value", out_data, {M363, M363});
      end
      chk("frames_done_1", 48'(frames_done), 48'd1);
      @(posedge clk); #1;
      chk("drain_valid", 48'(out_valid), 48'd0);

      // samples without sof in IDLE are dropped
      drop_samples(10);

      // backpressure at idx 20
      for (int i = 0; i <= 20; i++) send(i == 0, i + 1, 0, i, 1'b0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sof    = 1'b0;
      in_data   = {12'd22, 12'd0};
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_ready", 48'(in_ready), 48'd0);
         chk("stall_csd", 48'(mult_csd), 48'(csd_of(21)));
         @(posedge clk); #1;
         chk("stall_valid", 48'(out_valid), 48'd1);
         chk("stall_hold", out_data, mult_model({12'd21, 12'd0}, csd_of(20)));
      end
      out_ready = 1'b1;
      for (int i = 21; i < 50; i++) send(1'b0, i + 1, 0, i, 1'b0);
      chk("frames_done_mid", 48'(frames_done), 48'd1);

      // out-of-place sof at idx 50
      send(1'b1, 200, 3, 0, 1'b0);
      chk("frame_err_pulse", 48'(frame_err), 48'd1);
      send(1'b0, 7, -2, 1, 1'b0);
      chk("frame_err_clear", 48'(frame_err), 48'd0);
      chk("frames_done_abort", 48'(frames_done), 48'd1);

      // reset mid-frame at idx 70 with a held output
      for (int i = 2; i <= 70; i++) send(1'b0, i, -i, i, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_valid", 48'(out_valid), 48'd0);
      chk("midrst_data", out_data, 48'd0);
      chk("midrst_frames", 48'(frames_done), 48'd0);
      drop_samples(5);

      // fresh full frame with varied data
      for (int i = 0; i < NFFT; i++) begin
         send(i == 0, (i * 13) % 1000 - 500, (i * 7) % 300 - 150, i, i == NFFT - 1);
      end
      chk("frames_done_final", 48'(frames_done), 48'd1);
      @(posedge clk); #1;
      chk("final_drain", 48'(out_valid), 48'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
